// File: rtl/pipeline_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipeline_controller: run/step/halt sequencing and hazard stalls for a 5-stage
// pipeline. Optional single-step support is enabled by macro PIPE_CTRL_STEP_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pipeline_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic [4:0]           i_id_rs,
  input  logic [4:0]           i_id_rt,
  input  logic                 i_id_uses_rt,
  input  logic [1:0]           i_reg_in_jump,
  input  logic                 i_jump,
  input  logic                 i_halt_id,
  input  logic                 i_ex_mem_read,
  input  logic                 i_ex_reg_write,
  input  logic [4:0]           i_ex_write_reg,
  input  logic                 i_mem_mem_read,
  input  logic [4:0]           i_mem_write_reg,
  output logic                 o_pipe_enable,
  output logic                 o_stall,
  output logic                 o_pc_write,
  output logic                 o_ifid_write,
  output logic                 o_flush_if,
  output logic                 o_halted,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
`ifdef PIPE_CTRL_STEP_EN
    S_STEP   = 3'd2,
`endif
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_drain_cnt;
  logic [3:0]             w_drain_nxt;
  logic                   r_pipe_enable;
  logic                   r_halted;
  logic                   r_cmd_ready;
  logic [CNT_WIDTH-1:0]   r_cycle_cnt;

  logic w_abort;
  logic w_run;
  logic w_step;
  logic w_load_use;
  logic w_br_ex;
  logic w_br_mem;
  logic w_stall;
  logic w_advance;
  logic w_halt_go;

  assign w_abort = i_cmd_valid && (i_cmd == 2'b11);
  assign w_run   = i_cmd_valid && (i_cmd == 2'b01);
`ifdef PIPE_CTRL_STEP_EN
  assign w_step  = i_cmd_valid && (i_cmd == 2'b10);
`else
  assign w_step  = 1'b0;
`endif

  assign w_load_use = i_ex_mem_read && (i_ex_write_reg != 5'd0) &&
                      ((i_ex_write_reg == i_id_rs) ||
                       (i_id_uses_rt && (i_ex_write_reg == i_id_rt)));

  // rt only participates in the compare-branch form (rs+rt)
  assign w_br_ex  = i_ex_reg_write && (i_ex_write_reg != 5'd0) && (i_reg_in_jump != 2'b00) &&
                    ((i_ex_write_reg == i_id_rs) ||
                     ((i_reg_in_jump == 2'b01) && (i_ex_write_reg == i_id_rt)));
  assign w_br_mem = i_mem_mem_read && (i_mem_write_reg != 5'd0) && (i_reg_in_jump != 2'b00) &&
                    ((i_mem_write_reg == i_id_rs) ||
                     ((i_reg_in_jump == 2'b01) && (i_mem_write_reg == i_id_rt)));

  assign w_stall   = (w_load_use || w_br_ex || w_br_mem) && r_pipe_enable;
  assign w_advance = r_pipe_enable && !w_stall && (r_state != S_DRAIN);
  assign w_halt_go = i_halt_id && !w_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_drain_nxt = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_run)
            w_state_nxt = S_RUN;
`ifdef PIPE_CTRL_STEP_EN
          else if (w_step)
            w_state_nxt = S_STEP;
`endif
        end
        S_RUN: begin
          if (w_halt_go) begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = c_DRAIN_LOAD;
          end
        end
`ifdef PIPE_CTRL_STEP_EN
        S_STEP: begin
          if (w_halt_go) begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = c_DRAIN_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
`endif
        S_DRAIN: begin
          if (r_drain_cnt == 4'd0)
            w_state_nxt = S_HALTED;
          else
            w_drain_nxt = r_drain_cnt - 4'd1;
        end
        S_HALTED: w_state_nxt = S_HALTED;
        default: begin
          w_state_nxt = S_IDLE;
          w_drain_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_drain_cnt   <= 4'd0;
      r_pipe_enable <= 1'b0;
      r_halted      <= 1'b0;
      r_cmd_ready   <= 1'b1;
      r_cycle_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain_cnt   <= w_drain_nxt;
      r_pipe_enable <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_HALTED));
      r_halted      <= (w_state_nxt == S_HALTED);
      r_cmd_ready   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_HALTED);
      if (w_abort)
        r_cycle_cnt <= '0;
      else if (r_pipe_enable && !(&r_cycle_cnt))
        r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_pipe_enable = r_pipe_enable;
  assign o_stall       = w_stall;
  assign o_pc_write    = w_advance;
  assign o_ifid_write  = w_advance;
  assign o_flush_if    = i_jump && w_advance;
  assign o_halted      = r_halted;
  assign o_cycle_count = r_cycle_cnt;

endmodule
`default_nettype wire

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 4, meaning cycles spent draining EX/MEM/WB after a HALT is decoded (1..15).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32, meaning width of the enabled-cycle counter.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports: i_clk  in  1  rising-edge clock; i_reset_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have the following command ports: i_cmd_valid  in  1  command strobe; i_cmd  in  2  01 run, 10 step, 11 abort, 00 no-op; o_cmd_ready  out  1  command accepted this cycle.
REQ-005 The block SHALL have the following ID-stage ports: i_id_rs  in  5; i_id_rt  in  5; i_id_uses_rt  in  1  instruction reads rt; i_reg_in_jump  in  2  00 none, 01 rs+rt, 10 rs only; i_jump  in  1  ID jump taken; i_halt_id  in  1  HALT word in ID.
REQ-006 The block SHALL have the following EX/MEM hazard ports: i_ex_mem_read  in  1; i_ex_reg_write  in  1; i_ex_write_reg  in  5; i_mem_mem_read  in  1; i_mem_write_reg  in  5.
REQ-007 The block SHALL have the following pipeline-control ports: o_pipe_enable  out  1  global enable (stages use ~o_pipe_enable as i_halt); o_stall  out  1  to ID i_stall; o_pc_write  out  1; o_ifid_write  out  1; o_flush_if  out  1; o_halted  out  1; o_cycle_count  out  CNT_WIDTH.

Function
REQ-008 The block SHALL implement state machine states IDLE, RUN, STEP, DRAIN and HALTED.
REQ-009 The state machine SHALL make these command transitions: IDLE+run->RUN; IDLE+step->STEP; STEP->IDLE after exactly one cycle; abort from any state->IDLE on the next edge.
REQ-010 The block SHALL drive o_cmd_ready=1 in IDLE and HALTED and 0 otherwise; abort SHALL be accepted in every state regardless of o_cmd_ready; run or step outside IDLE SHALL be ignored.
REQ-011 The block SHALL drive o_pipe_enable=1 in RUN, STEP and DRAIN and 0 in IDLE and HALTED.
REQ-012 The block SHALL assert load-use hazard when i_ex_mem_read=1, i_ex_write_reg!=0, and i_ex_write_reg equals i_id_rs, or equals i_id_rt with i_id_uses_rt=1.
REQ-013 The block SHALL assert branch hazard when i_reg_in_jump!=00 and the register matches i_id_rs, or matches i_id_rt when i_reg_in_jump=01, for either of two sources: i_ex_reg_write=1 with nonzero i_ex_write_reg, or i_mem_mem_read=1 with nonzero i_mem_write_reg.
REQ-014 The block SHALL drive o_stall combinationally as (load-use OR branch hazard) AND o_pipe_enable.
REQ-015 The block SHALL drive o_pc_write and o_ifid_write as o_pipe_enable AND ~o_stall AND state!=DRAIN.
REQ-016 The block SHALL drive o_flush_if as i_jump AND o_pipe_enable AND ~o_stall AND state!=DRAIN; a stall SHALL suppress the flush.
REQ-017 When i_halt_id=1 with ~o_stall in RUN or STEP, the block SHALL enter DRAIN on the next edge, load the drain counter with DRAIN_CYCLES-1, decrement it each cycle, and enter HALTED when it reaches 0, giving exactly DRAIN_CYCLES DRAIN cycles.
REQ-018 When i_halt_id=1 and a step is in progress, the block SHALL let the halt take priority over STEP->IDLE.
REQ-019 The block SHALL drive o_halted=1 only in HALTED; HALTED SHALL be left only by abort.
REQ-020 The block SHALL increment o_cycle_count every cycle o_pipe_enable=1, saturate it at all-ones, and clear it to 0 on abort; abort SHALL take priority over an increment in the same cycle.
REQ-021 On an abort arriving in DRAIN, the block SHALL go to IDLE and clear the drain counter.

Reset
REQ-022 Asserting i_reset_n=0 SHALL, asynchronously, set state=IDLE, drain counter=0, o_cycle_count=0, o_halted=0, o_pipe_enable=0, o_stall=0, o_pc_write=0, o_ifid_write=0, o_flush_if=0 and o_cmd_ready=1.
REQ-023 The block SHALL release from reset synchronously to the first rising i_clk with i_reset_n=1; reset mid-DRAIN SHALL discard the drain.

Configuration
REQ-024 The block SHALL support macro PIPE_CTRL_STEP_EN: when defined, step commands and the STEP state SHALL behave as in REQ-009; when undefined, STEP SHALL not exist, i_cmd=10 SHALL be treated as no-op, and o_cmd_ready behaviour SHALL be unchanged.

Verification
REQ-025 The bench SHALL cover: reset released, i_cmd_valid=1 i_cmd=01 -> o_pipe_enable=1 next cycle, o_cycle_count=1 after one enabled cycle.
REQ-026 The bench SHALL cover: RUN, i_ex_mem_read=1 i_ex_write_reg=5 i_id_rs=5 -> o_stall=1, o_pc_write=0, o_ifid_write=0 same cycle; with i_ex_write_reg=0 -> o_stall=0.
REQ-027 The bench SHALL cover: RUN, i_reg_in_jump=01 i_id_rt=7 i_mem_mem_read=1 i_mem_write_reg=7 i_jump=1 -> o_stall=1, o_flush_if=0; next cycle with the hazard cleared -> o_flush_if=1.
REQ-028 The bench SHALL cover: RUN, i_halt_id=1 -> DRAIN with o_pc_write=0 for 4 cycles, then o_halted=1, o_pipe_enable=0, o_cycle_count frozen.
REQ-029 The bench SHALL cover: with PIPE_CTRL_STEP_EN defined, IDLE + step -> o_pipe_enable=1 for exactly one cycle; without it -> o_pipe_enable stays 0.
REQ-030 The bench SHALL cover: abort during DRAIN and i_reset_n pulsed low mid-RUN -> IDLE, o_cycle_count=0, o_cmd_ready=1.
